// File: rtl/jk_pkg.sv
// jk_pkg: mode encodings shared by the JK register bank
package jk_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_JK  = 2'b00;
  localparam mode_t MODE_UP  = 2'b01;
  localparam mode_t MODE_DN  = 2'b10;
  localparam mode_t MODE_SHL = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with sync reset value, parallel load and clock enable
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ld,
  input  logic ld_d,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk)
    if (rst) q <= rst_val;
    else if (ld) q <= ld_d;
    else if (ce) q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit JK cell bank acting as JK register, up/down counter or shift register
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tc
);
  logic [WIDTH-1:0] t_up, t_dn, src, jm, km;
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  assign src = {q[WIDTH-2:0], sin};
  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_cell
    if (g > 0) begin : g_t
      assign t_up[g] = &q[g-1:0];
      assign t_dn[g] = ~|q[g-1:0];
    end
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[g]),
      .ld      (load),
      .ld_d    (d[g]),
      .ce      (en),
      .j       (jm[g]),
      .k       (km[g]),
      .q       (q[g])
    );
  end
  always_comb begin
    jm = mode == MODE_JK ? j : mode == MODE_UP ? t_up : mode == MODE_DN ? t_dn : src;
    km = mode == MODE_JK ? k : mode == MODE_SHL ? ~src : jm;
  end
  assign sout = q[WIDTH-1];
  assign tc = en & ~load & ~rst & ((mode == MODE_UP & (&q)) | (mode == MODE_DN & ~|q));
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed and randomized checks of jk_reg_bank against a behavioural model
module tb_jk_reg_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, load = 1'b0, sin = 1'b0;
  logic [3:0] d = '0, j = '0, k = '0;
  logic [1:0] mode = '0;
  logic [3:0] q;
  logic       sout, tc;
  logic [3:0] mq;
  logic       mvalid = 1'b0;
  int         n_tests = 0, n_fail = 0;

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'hF)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .d    (d),
    .mode (mode),
    .j    (j),
    .k    (k),
    .sin  (sin),
    .q    (q),
    .sout (sout),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic e, input logic [1:0] m,
                       input logic [3:0] dd, input logic [3:0] jj, input logic [3:0] kk,
                       input logic s, input string tag);
    logic exp_tc;
    rst = r; load = l; en = e; mode = m; d = dd; j = jj; k = kk; sin = s;
    #1;
    exp_tc = e && !l && !r && mvalid && ((m == 2'd1 && mq == 4'hF) || (m == 2'd2 && mq == 4'h0));
    if (mvalid || r) check({tag, ".tc"}, tc, exp_tc);
    if (mvalid) check({tag, ".sout"}, sout, mq[3]);
    @(posedge clk);
    if (r) begin
      mq = 4'hF;
      mvalid = 1'b1;
    end else if (l) begin
      mq = dd;
      mvalid = 1'b1;
    end else if (e) begin
      case (m)
        2'd0:
          for (int i = 0; i < 4; i++)
            case ({jj[i], kk[i]})
              2'b01:   mq[i] = 1'b0;
              2'b10:   mq[i] = 1'b1;
              2'b11:   mq[i] = ~mq[i];
              default: ;
            endcase
        2'd1: mq = 4'((int'(mq) + 1) % 16);
        2'd2: mq = 4'((int'(mq) + 15) % 16);
        default: mq = 4'(((int'(mq) << 1) | int'(s)) % 16);
      endcase
    end
    #1;
    if (mvalid) check({tag, ".q"}, q, mq);
  endtask

  initial begin
    cycle(1, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0, "rst");
    check("rst_val", q, 4'hF);
    cycle(0, 0, 0, 2'd1, 4'h0, 4'h0, 4'h0, 0, "hold");
    cycle(0, 1, 0, 2'd0, 4'hA, 4'h0, 4'h0, 0, "ld_a");
    cycle(0, 0, 1, 2'd0, 4'h0, 4'h3, 4'h5, 0, "jk");
    check("jk_abs", q, 4'hB);
    cycle(0, 1, 0, 2'd1, 4'hD, 4'h0, 4'h0, 0, "ld_d");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 2'd1, 4'h0, 4'hF, 4'h0, 1, "up");
    check("up_abs", q, 4'h1);
    cycle(0, 1, 0, 2'd2, 4'h1, 4'h0, 4'h0, 0, "ld_1");
    cycle(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0, "dn");
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0, 0, "dn_hold");
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0, 0, "dn");
    check("dn_abs", q, 4'hE);
    cycle(1, 0, 0, 2'd3, 4'h0, 4'h0, 4'h0, 0, "sh_rst");
    cycle(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 0, "sh0");
    cycle(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 1, "sh1");
    cycle(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 0, "sh2");
    cycle(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0, 0, "sh3");
    check("sh_abs", q, 4'h4);
    cycle(0, 1, 1, 2'd1, 4'h6, 4'h0, 4'h0, 0, "ld_pri");
    check("ld_pri_abs", q, 4'h6);
    cycle(1, 1, 1, 2'd1, 4'h6, 4'h0, 4'h0, 0, "rst_pri");
    cycle(0, 1, 0, 2'd1, 4'h3, 4'h0, 4'h0, 0, "ld_3");
    cycle(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0, "mid_up");
    cycle(1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0, "mid_rst");
    cycle(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0, 0, "resume");
    check("resume_abs", q, 4'h0);
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), "rnd");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
